n101_subsys_excl_arb: RTL and testbench
=======================================

// Module: n101_subsys_excl_arb
// PURPOSE
//  Two-master ICB arbiter placed in front of the subsystem exclusive monitor.
//  Shares one downstream ICB port between M0 (core LSU) and M1 (debug/DMA).
//  Honours cmd_lock bus locking and forwards excl/excl_ok so LR/SC still work.
//  Returns each response to its issuing master, in order, via a route queue.
// PARAMETERS
//  OUTS_DP   2   route-queue depth = maximum outstanding downstream commands (>=1)
//  AW        `N101_ADDR_SIZE   address width
//  DW        `N101_XLEN        data width; wmask width is DW/8
// PORTS
//  clk                 in   1     clock
//  rst                 in   1     synchronous active-high reset
//  mN_icb_cmd_valid    in   1     N=0,1: command valid
//  mN_icb_cmd_ready    out  1     N=0,1: command accepted
//  mN_icb_cmd_addr     in   AW    N=0,1: address
//  mN_icb_cmd_read     in   1     N=0,1: 1=read, 0=write
//  mN_icb_cmd_wdata    in   DW    N=0,1: write data
//  mN_icb_cmd_wmask    in   DW/8  N=0,1: byte mask
//  mN_icb_cmd_lock     in   1     N=0,1: bus-lock request
//  mN_icb_cmd_excl     in   1     N=0,1: exclusive (LR/SC)
//  mN_icb_cmd_size     in   2     N=0,1: access size
//  mN_icb_rsp_valid    out  1     N=0,1: response valid
//  mN_icb_rsp_ready    in   1     N=0,1: response accepted
//  mN_icb_rsp_err      out  1     N=0,1: error
//  mN_icb_rsp_excl_ok  out  1     N=0,1: SC success
//  mN_icb_rsp_rdata    out  DW    N=0,1: read data
//  o_icb_cmd_*         out  —     valid/addr/read/wdata/wmask/lock/excl/size to monitor
//  o_icb_cmd_ready     in   1     downstream accept
//  o_icb_rsp_valid/err/excl_ok/rdata  in   —   downstream response
//  o_icb_rsp_ready     out  1     downstream response accept
// BEHAVIOUR
//  Reset: lock_vld=0, lock_own=0, rr_last=1 (M0 is favoured first), route queue empty.
//   All valid/ready outputs are 0 after reset until a master asserts valid.
//  Grant (combinational):
//   - lock_vld=1: only lock_own is eligible; the other master's cmd_ready=0.
//   - lock_vld=0: arbitrate among valid masters (see CONFIGURATION).
//   - Queue full: o_icb_cmd_valid=0 and both cmd_ready=0. A pop in the same
//     cycle does not relieve full; this keeps the ready path registered-only.
//   - o_icb_cmd_* = granted master's fields; mG_cmd_ready = o_icb_cmd_ready & ~full.
//   - Zero added latency: the command passes through in the same cycle.
//  Accept = o_icb_cmd_valid & o_icb_cmd_ready:
//   - Push the granted id (1 bit) into the route queue.
//   - lock=1: set lock_vld and lock_own=id.
//   - Owner command with lock=0: clear lock_vld; this command itself is still owned.
//   - Update rr_last=id only while lock_vld=0 before the accept.
//  Response:
//   - Head id H routes o_icb_rsp_* to mH_rsp_*; the other master's rsp_valid=0.
//   - o_icb_rsp_ready = mH_rsp_ready & ~empty. Pop on the o-side response handshake.
//   - Queue empty: o_icb_rsp_ready=0 and rsp_valid outputs=0. A stray response stalls.
//  Simultaneous push and pop when not full: count is unchanged and pointers wrap mod OUTS_DP.
//  Reset mid-transaction: all state clears and in-flight responses are discarded;
//   the downstream is reset in the same domain.
//  Invariant: the queue count is never >OUTS_DP and never <0.
// CONFIGURATION
//  N101_EXCL_ARB_RR_EN defined: round-robin. On contention, grant the master
//   that is not rr_last.
//  Undefined: fixed priority, M0 always wins. rr_last is not instantiated.
// STRUCTURE
//  n101_defines.v provides N101_ADDR_SIZE, N101_XLEN and a new N101_EXCL_ARB_OUTS_DP default.
//  Sub-module n101_excl_arb_rspq: a 1-bit, OUTS_DP-deep sync FIFO with
//   full/empty and count; push/pop rules are as above.
//  The top level holds the arbiter, lock registers and muxes.
// TESTING
//  1 Reset, then M0 read 0x100 alone -> o_icb_cmd_addr=0x100 in the same cycle;
//    response rdata 0xA5 goes to M0 only; m1_rsp_valid stays 0.
//  2 Both valid every cycle, 4 cmds, RR_EN -> grant order M0,M1,M0,M1.
//    Without RR_EN -> M0 x4 while M1 is stalled.
//  3 M1 lock=1 write, then M0 valid -> M0 cmd_ready=0 until M1 issues lock=0.
//    The M0 grant occurs the cycle after that accept.
//  4 OUTS_DP=2, downstream rsp held off -> 3rd cmd blocked (both cmd_ready=0).
//    Release one rsp -> 3rd accepted the following cycle.
//  5 M0 LR 0x200, M1 LR 0x200, M0 SC 0x200 -> excl_ok is forwarded to the
//    correct master and responses stay in issue order.
//  6 Assert rst with 2 outstanding -> next cycle: queue empty, lock_vld=0,
//    o_icb_rsp_ready=0.

Source files
------------

// File: rtl/n101_subsys_excl_arb_pkg.sv
// Shared types and default sizes for the two-master exclusive-monitor arbiter.
// Defaults apply only when n101_defines.v has not already set the macros.

`ifndef N101_ADDR_SIZE
`define N101_ADDR_SIZE 32
`endif
`ifndef N101_XLEN
`define N101_XLEN 32
`endif
`ifndef N101_EXCL_ARB_OUTS_DP
`define N101_EXCL_ARB_OUTS_DP 2
`endif

package n101_subsys_excl_arb_pkg;

    localparam int N101_AW      = `N101_ADDR_SIZE;
    localparam int N101_DW      = `N101_XLEN;
    localparam int N101_OUTS_DP = `N101_EXCL_ARB_OUTS_DP;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_id_e;

    function automatic int ptr_w(input int dp);
        return (dp > 1) ? $clog2(dp) : 1;
    endfunction

endpackage

// File: rtl/n101_excl_arb_rspq.sv
// Route queue: 1-bit master ids, OUTS_DP deep, sync FIFO with full/empty/count.
// Ports: clk, rst, push/push_id, pop, head_id, full, empty, count.

module n101_excl_arb_rspq
    import n101_subsys_excl_arb_pkg::*;
#(
    parameter int DP = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       push_id,
    input  logic                       pop,
    output logic                       head_id,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DP+1)-1:0]    count
);

    localparam int PW = ptr_w(DP);
    localparam int CW = $clog2(DP + 1);

    logic [DP-1:0] mem;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(
        input logic [PW-1:0] p
    );
        if (p == PW'(DP - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (cnt == CW'(DP));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head_id = mem[rptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_id;
                wptr      <= nxt(wptr);
            end
            if (do_pop) begin
                rptr <= nxt(rptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/n101_subsys_excl_arb.sv
// Two-master ICB arbiter in front of the exclusive monitor, with bus lock
// and in-order response routing. Option macro: N101_EXCL_ARB_RR_EN.
// Ports: clk, rst, m0_icb_*, m1_icb_* (upstream), o_icb_* (downstream).

module n101_subsys_excl_arb
    import n101_subsys_excl_arb_pkg::*;
#(
    parameter int OUTS_DP = N101_OUTS_DP,
    parameter int AW      = N101_AW,
    parameter int DW      = N101_DW
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic            m0_icb_cmd_read,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    input  logic            m0_icb_cmd_lock,
    input  logic            m0_icb_cmd_excl,
    input  logic [1:0]      m0_icb_cmd_size,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic            m0_icb_rsp_err,
    output logic            m0_icb_rsp_excl_ok,
    output logic [DW-1:0]   m0_icb_rsp_rdata,

    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic            m1_icb_cmd_read,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    input  logic            m1_icb_cmd_lock,
    input  logic            m1_icb_cmd_excl,
    input  logic [1:0]      m1_icb_cmd_size,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic            m1_icb_rsp_err,
    output logic            m1_icb_rsp_excl_ok,
    output logic [DW-1:0]   m1_icb_rsp_rdata,

    output logic            o_icb_cmd_valid,
    input  logic            o_icb_cmd_ready,
    output logic [AW-1:0]   o_icb_cmd_addr,
    output logic            o_icb_cmd_read,
    output logic [DW-1:0]   o_icb_cmd_wdata,
    output logic [DW/8-1:0] o_icb_cmd_wmask,
    output logic            o_icb_cmd_lock,
    output logic            o_icb_cmd_excl,
    output logic [1:0]      o_icb_cmd_size,
    input  logic            o_icb_rsp_valid,
    output logic            o_icb_rsp_ready,
    input  logic            o_icb_rsp_err,
    input  logic            o_icb_rsp_excl_ok,
    input  logic [DW-1:0]   o_icb_rsp_rdata
);

    localparam int CW = $clog2(OUTS_DP + 1);

    logic          lock_vld;
    mst_id_e       lock_own;
    mst_id_e       gnt_id;
    mst_id_e       pick_both;
    logic          gnt_vld;
    logic [1:0]    m_vld;
    logic          cmd_acc;
    logic          q_full;
    logic          q_empty;
    logic          q_head;
    logic [CW-1:0] q_cnt;
    logic          rsp_sel_m1;
    logic          rsp_acc;

`ifdef N101_EXCL_ARB_RR_EN
    mst_id_e       rr_last;

    // On contention the master that did not win last time goes first.
    assign pick_both = (rr_last == MST_M1) ? MST_M0 : MST_M1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= MST_M1;
        end else if (cmd_acc && !lock_vld) begin
            rr_last <= gnt_id;
        end
    end
`else
    assign pick_both = MST_M0;
`endif

    assign m_vld = {m1_icb_cmd_valid, m0_icb_cmd_valid};

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = MST_M0;
        if (lock_vld) begin
            gnt_vld = m_vld[lock_own];
            gnt_id  = lock_own;
        end else begin
            unique case (1'b1)
                (m_vld == 2'b11): begin
                    gnt_vld = 1'b1;
                    gnt_id  = pick_both;
                end
                (m_vld == 2'b01): begin
                    gnt_vld = 1'b1;
                    gnt_id  = MST_M0;
                end
                (m_vld == 2'b10): begin
                    gnt_vld = 1'b1;
                    gnt_id  = MST_M1;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_id  = MST_M0;
                end
            endcase
        end
    end

    // Full blocks the grant even if a pop is happening, so the
    // ready path depends on registered queue state only.
    assign o_icb_cmd_valid = gnt_vld & ~q_full;
    assign cmd_acc = o_icb_cmd_valid & o_icb_cmd_ready;

    assign m0_icb_cmd_ready = gnt_vld & (gnt_id == MST_M0)
                            & o_icb_cmd_ready & ~q_full;
    assign m1_icb_cmd_ready = gnt_vld & (gnt_id == MST_M1)
                            & o_icb_cmd_ready & ~q_full;

    always_comb begin
        if (gnt_id == MST_M1) begin
            o_icb_cmd_addr  = m1_icb_cmd_addr;
            o_icb_cmd_read  = m1_icb_cmd_read;
            o_icb_cmd_wdata = m1_icb_cmd_wdata;
            o_icb_cmd_wmask = m1_icb_cmd_wmask;
            o_icb_cmd_lock  = m1_icb_cmd_lock;
            o_icb_cmd_excl  = m1_icb_cmd_excl;
            o_icb_cmd_size  = m1_icb_cmd_size;
        end else begin
            o_icb_cmd_addr  = m0_icb_cmd_addr;
            o_icb_cmd_read  = m0_icb_cmd_read;
            o_icb_cmd_wdata = m0_icb_cmd_wdata;
            o_icb_cmd_wmask = m0_icb_cmd_wmask;
            o_icb_cmd_lock  = m0_icb_cmd_lock;
            o_icb_cmd_excl  = m0_icb_cmd_excl;
            o_icb_cmd_size  = m0_icb_cmd_size;
        end
    end

    // A lock=0 command from the owner releases the lock after itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_own <= MST_M0;
        end else if (cmd_acc) begin
            if (o_icb_cmd_lock) begin
                lock_vld <= 1'b1;
                lock_own <= gnt_id;
            end else if (lock_vld && gnt_id == lock_own) begin
                lock_vld <= 1'b0;
            end
        end
    end

    n101_excl_arb_rspq #(
        .DP (OUTS_DP)
    ) u_rspq (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_acc),
        .push_id (gnt_id),
        .pop     (rsp_acc),
        .head_id (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_cnt)
    );

    assign rsp_sel_m1 = (q_head == MST_M1);

    assign o_icb_rsp_ready = ~q_empty &
        (rsp_sel_m1 ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    assign rsp_acc = o_icb_rsp_valid & o_icb_rsp_ready;

    assign m0_icb_rsp_valid = o_icb_rsp_valid & ~q_empty & ~rsp_sel_m1;
    assign m1_icb_rsp_valid = o_icb_rsp_valid & ~q_empty &  rsp_sel_m1;

    assign m0_icb_rsp_err     = o_icb_rsp_err;
    assign m0_icb_rsp_excl_ok = o_icb_rsp_excl_ok;
    assign m0_icb_rsp_rdata   = o_icb_rsp_rdata;
    assign m1_icb_rsp_err     = o_icb_rsp_err;
    assign m1_icb_rsp_excl_ok = o_icb_rsp_excl_ok;
    assign m1_icb_rsp_rdata   = o_icb_rsp_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (q_cnt <= CW'(OUTS_DP));
        end
    end

endmodule

// File: tb/tb_n101_subsys_excl_arb.sv
// Directed self-checking bench for n101_subsys_excl_arb (OUTS_DP=2).
// Build with or without N101_EXCL_ARB_RR_EN.

module tb_n101_subsys_excl_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;

    logic            m0_cmd_valid, m0_cmd_ready;
    logic [AW-1:0]   m0_cmd_addr;
    logic            m0_cmd_read;
    logic [DW-1:0]   m0_cmd_wdata;
    logic [DW/8-1:0] m0_cmd_wmask;
    logic            m0_cmd_lock, m0_cmd_excl;
    logic [1:0]      m0_cmd_size;
    logic            m0_rsp_valid, m0_rsp_ready;
    logic            m0_rsp_err, m0_rsp_excl_ok;
    logic [DW-1:0]   m0_rsp_rdata;

    logic            m1_cmd_valid, m1_cmd_ready;
    logic [AW-1:0]   m1_cmd_addr;
    logic            m1_cmd_read;
    logic [DW-1:0]   m1_cmd_wdata;
    logic [DW/8-1:0] m1_cmd_wmask;
    logic            m1_cmd_lock, m1_cmd_excl;
    logic [1:0]      m1_cmd_size;
    logic            m1_rsp_valid, m1_rsp_ready;
    logic            m1_rsp_err, m1_rsp_excl_ok;
    logic [DW-1:0]   m1_rsp_rdata;

    logic            o_cmd_valid, o_cmd_ready;
    logic [AW-1:0]   o_cmd_addr;
    logic            o_cmd_read;
    logic [DW-1:0]   o_cmd_wdata;
    logic [DW/8-1:0] o_cmd_wmask;
    logic            o_cmd_lock, o_cmd_excl;
    logic [1:0]      o_cmd_size;
    logic            o_rsp_valid, o_rsp_ready;
    logic            o_rsp_err, o_rsp_excl_ok;
    logic [DW-1:0]   o_rsp_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    n101_subsys_excl_arb #(
        .OUTS_DP (2),
        .AW      (AW),
        .DW      (DW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .m0_icb_cmd_valid   (m0_cmd_valid),
        .m0_icb_cmd_ready   (m0_cmd_ready),
        .m0_icb_cmd_addr    (m0_cmd_addr),
        .m0_icb_cmd_read    (m0_cmd_read),
        .m0_icb_cmd_wdata   (m0_cmd_wdata),
        .m0_icb_cmd_wmask   (m0_cmd_wmask),
        .m0_icb_cmd_lock    (m0_cmd_lock),
        .m0_icb_cmd_excl    (m0_cmd_excl),
        .m0_icb_cmd_size    (m0_cmd_size),
        .m0_icb_rsp_valid   (m0_rsp_valid),
        .m0_icb_rsp_ready   (m0_rsp_ready),
        .m0_icb_rsp_err     (m0_rsp_err),
        .m0_icb_rsp_excl_ok (m0_rsp_excl_ok),
        .m0_icb_rsp_rdata   (m0_rsp_rdata),
        .m1_icb_cmd_valid   (m1_cmd_valid),
        .m1_icb_cmd_ready   (m1_cmd_ready),
        .m1_icb_cmd_addr    (m1_cmd_addr),
        .m1_icb_cmd_read    (m1_cmd_read),
        .m1_icb_cmd_wdata   (m1_cmd_wdata),
        .m1_icb_cmd_wmask   (m1_cmd_wmask),
        .m1_icb_cmd_lock    (m1_cmd_lock),
        .m1_icb_cmd_excl    (m1_cmd_excl),
        .m1_icb_cmd_size    (m1_cmd_size),
        .m1_icb_rsp_valid   (m1_rsp_valid),
        .m1_icb_rsp_ready   (m1_rsp_ready),
        .m1_icb_rsp_err     (m1_rsp_err),
        .m1_icb_rsp_excl_ok (m1_rsp_excl_ok),
        .m1_icb_rsp_rdata   (m1_rsp_rdata),
        .o_icb_cmd_valid    (o_cmd_valid),
        .o_icb_cmd_ready    (o_cmd_ready),
        .o_icb_cmd_addr     (o_cmd_addr),
        .o_icb_cmd_read     (o_cmd_read),
        .o_icb_cmd_wdata    (o_cmd_wdata),
        .o_icb_cmd_wmask    (o_cmd_wmask),
        .o_icb_cmd_lock     (o_cmd_lock),
        .o_icb_cmd_excl     (o_cmd_excl),
        .o_icb_cmd_size     (o_cmd_size),
        .o_icb_rsp_valid    (o_rsp_valid),
        .o_icb_rsp_ready    (o_rsp_ready),
        .o_icb_rsp_err      (o_rsp_err),
        .o_icb_rsp_excl_ok  (o_rsp_excl_ok),
        .o_icb_rsp_rdata    (o_rsp_rdata)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        m0_cmd_valid = 0; m0_cmd_addr = '0;
        m0_cmd_read = 1; m0_cmd_wdata = '0;
        m0_cmd_wmask = '0; m0_cmd_lock = 0;
        m0_cmd_excl = 0; m0_cmd_size = 2'd2;
        m1_cmd_valid = 0; m1_cmd_addr = '0;
        m1_cmd_read = 1; m1_cmd_wdata = '0;
        m1_cmd_wmask = '0; m1_cmd_lock = 0;
        m1_cmd_excl = 0; m1_cmd_size = 2'd2;
        m0_rsp_ready = 1; m1_rsp_ready = 1;
        o_cmd_ready = 1; o_rsp_valid = 0;
        o_rsp_err = 0; o_rsp_excl_ok = 0;
        o_rsp_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        settle();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_o_cmd_valid", 64'(o_cmd_valid), 0);
        chk("rst_m0_cmd_ready", 64'(m0_cmd_ready), 0);
        chk("rst_m1_cmd_ready", 64'(m1_cmd_ready), 0);
        chk("rst_o_rsp_ready", 64'(o_rsp_ready), 0);
        o_rsp_valid = 1;
        settle();
        chk("rst_stray_m0v", 64'(m0_rsp_valid), 0);
        chk("rst_stray_m1v", 64'(m1_rsp_valid), 0);
        chk("rst_stray_ordy", 64'(o_rsp_ready), 0);
        o_rsp_valid = 0;

        // 1: M0 read passes through same cycle
        tick();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h100;
        m0_cmd_read = 1; m0_cmd_size = 2'd1;
        settle();
        chk("t1_o_valid", 64'(o_cmd_valid), 1);
        chk("t1_o_addr", 64'(o_cmd_addr), 64'h100);
        chk("t1_o_read", 64'(o_cmd_read), 1);
        chk("t1_o_size", 64'(o_cmd_size), 1);
        chk("t1_m0_rdy", 64'(m0_cmd_ready), 1);
        chk("t1_m1_rdy", 64'(m1_cmd_ready), 0);
        tick();
        m0_cmd_valid = 0;
        o_rsp_valid = 1; o_rsp_rdata = 32'hA5;
        o_rsp_err = 1;
        settle();
        chk("t1_m0_rspv", 64'(m0_rsp_valid), 1);
        chk("t1_m0_rdata", 64'(m0_rsp_rdata), 64'hA5);
        chk("t1_m0_err", 64'(m0_rsp_err), 1);
        chk("t1_m1_rspv", 64'(m1_rsp_valid), 0);
        chk("t1_o_rsp_rdy", 64'(o_rsp_ready), 1);
        tick();
        o_rsp_valid = 0; o_rsp_err = 0;
        settle();
        chk("t1_empty_rdy", 64'(o_rsp_ready), 0);

        // 2: contention, downstream answers each cycle
        do_reset();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h10;
        m1_cmd_valid = 1; m1_cmd_addr = 32'h20;
        o_rsp_valid = 1;
        for (int i = 0; i < 4; i++) begin
            logic exp_m1;
`ifdef N101_EXCL_ARB_RR_EN
            exp_m1 = (i % 2) == 1;
`else
            exp_m1 = 1'b0;
`endif
            settle();
            chk($sformatf("t2_m0_rdy_%0d", i),
                64'(m0_cmd_ready), 64'(!exp_m1));
            chk($sformatf("t2_m1_rdy_%0d", i),
                64'(m1_cmd_ready), 64'(exp_m1));
            chk($sformatf("t2_addr_%0d", i),
                64'(o_cmd_addr),
                exp_m1 ? 64'h20 : 64'h10);
            tick();
        end
        m0_cmd_valid = 0; m1_cmd_valid = 0;
        tick();
        o_rsp_valid = 0;
        settle();
        chk("t2_drained", 64'(o_rsp_ready), 0);

        // 3: M1 bus lock holds off M0
        do_reset();
        o_rsp_valid = 1;
        m1_cmd_valid = 1; m1_cmd_addr = 32'h300;
        m1_cmd_read = 0; m1_cmd_lock = 1;
        m1_cmd_wdata = 32'hDEADBEEF;
        m1_cmd_wmask = 4'hC;
        settle();
        chk("t3_m1_rdy", 64'(m1_cmd_ready), 1);
        chk("t3_o_lock", 64'(o_cmd_lock), 1);
        chk("t3_o_wdata", 64'(o_cmd_wdata),
            64'hDEADBEEF);
        chk("t3_o_wmask", 64'(o_cmd_wmask), 64'hC);
        tick();
        m1_cmd_valid = 0; m1_cmd_lock = 0;
        m0_cmd_valid = 1; m0_cmd_addr = 32'h310;
        settle();
        chk("t3_m1_rspv", 64'(m1_rsp_valid), 1);
        chk("t3_m0_blk_a", 64'(m0_cmd_ready), 0);
        chk("t3_o_vld_a", 64'(o_cmd_valid), 0);
        tick();
        m1_cmd_valid = 1; m1_cmd_addr = 32'h304;
        settle();
        chk("t3_m1_unlk", 64'(m1_cmd_ready), 1);
        chk("t3_m0_blk_b", 64'(m0_cmd_ready), 0);
        tick();
        m1_cmd_valid = 0;
        settle();
        chk("t3_m0_gnt", 64'(m0_cmd_ready), 1);
        chk("t3_m0_addr", 64'(o_cmd_addr), 64'h310);
        tick();
        m0_cmd_valid = 0;
        tick();
        o_rsp_valid = 0;
        settle();
        chk("t3_drained", 64'(o_rsp_ready), 0);

        // 4: queue full blocks the third command
        do_reset();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h400;
        tick();
        tick();
        m1_cmd_valid = 1; m1_cmd_addr = 32'h404;
        settle();
        chk("t4_full_ovld", 64'(o_cmd_valid), 0);
        chk("t4_full_m0", 64'(m0_cmd_ready), 0);
        chk("t4_full_m1", 64'(m1_cmd_ready), 0);
        m1_cmd_valid = 0;
        o_rsp_valid = 1; o_rsp_rdata = 32'h11;
        settle();
        chk("t4_pop_ordy", 64'(o_rsp_ready), 1);
        chk("t4_pop_m0v", 64'(m0_rsp_valid), 1);
        chk("t4_pop_keep", 64'(m0_cmd_ready), 0);
        tick();
        o_rsp_valid = 0;
        settle();
        chk("t4_third_rdy", 64'(m0_cmd_ready), 1);
        chk("t4_third_vld", 64'(o_cmd_valid), 1);
        tick();
        m0_cmd_valid = 0;
        o_rsp_valid = 1;
        tick();
        tick();
        o_rsp_valid = 0;
        settle();
        chk("t4_drained", 64'(o_rsp_ready), 0);

        // 5: LR/SC ordering and excl_ok routing
        do_reset();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h200;
        m0_cmd_excl = 1; m0_cmd_read = 1;
        settle();
        chk("t5_lr0_excl", 64'(o_cmd_excl), 1);
        tick();
        m0_cmd_valid = 0;
        m1_cmd_valid = 1; m1_cmd_addr = 32'h200;
        m1_cmd_excl = 1; m1_cmd_read = 1;
        settle();
        chk("t5_lr1_rdy", 64'(m1_cmd_ready), 1);
        tick();
        m1_cmd_valid = 0;
        o_rsp_valid = 1; o_rsp_excl_ok = 1;
        o_rsp_rdata = 32'h55;
        settle();
        chk("t5_r0_m0v", 64'(m0_rsp_valid), 1);
        chk("t5_r0_m1v", 64'(m1_rsp_valid), 0);
        chk("t5_r0_ok", 64'(m0_rsp_excl_ok), 1);
        tick();
        m0_cmd_valid = 1; m0_cmd_read = 0;
        m0_cmd_wdata = 32'h77;
        o_rsp_rdata = 32'h66;
        settle();
        chk("t5_r1_m1v", 64'(m1_rsp_valid), 1);
        chk("t5_r1_m0v", 64'(m0_rsp_valid), 0);
        chk("t5_r1_ok", 64'(m1_rsp_excl_ok), 1);
        chk("t5_r1_data", 64'(m1_rsp_rdata), 64'h66);
        chk("t5_sc_rdy", 64'(m0_cmd_ready), 1);
        chk("t5_sc_read", 64'(o_cmd_read), 0);
        chk("t5_sc_excl", 64'(o_cmd_excl), 1);
        tick();
        m0_cmd_valid = 0; m0_cmd_excl = 0;
        o_rsp_excl_ok = 0; o_rsp_rdata = 32'h1;
        settle();
        chk("t5_r2_m0v", 64'(m0_rsp_valid), 1);
        chk("t5_r2_m1v", 64'(m1_rsp_valid), 0);
        chk("t5_r2_ok", 64'(m0_rsp_excl_ok), 0);
        tick();
        o_rsp_valid = 0;
        settle();
        chk("t5_drained", 64'(o_rsp_ready), 0);

        // 6: reset with two outstanding and lock held
        do_reset();
        m0_cmd_valid = 1; m0_cmd_lock = 1;
        m0_cmd_addr = 32'h600;
        tick();
        tick();
        m0_cmd_valid = 0; m0_cmd_lock = 0;
        m1_cmd_valid = 1;
        settle();
        chk("t6_pre_m1", 64'(m1_cmd_ready), 0);
        rst = 1;
        tick();
        rst = 0;
        o_rsp_valid = 1;
        settle();
        chk("t6_ordy", 64'(o_rsp_ready), 0);
        chk("t6_m0v", 64'(m0_rsp_valid), 0);
        chk("t6_m1v", 64'(m1_rsp_valid), 0);
        chk("t6_unlock", 64'(m1_cmd_ready), 1);
        tick();
        o_rsp_valid = 0;
        m1_cmd_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
